// File: rtl/snn_conv_mac_if.sv
// Handshake bundle for snn_conv_mac: filter load, ifmap window stream and result channel.
// Also carries the per-run configuration (spike_mode, threshold) sampled on filter accept.
interface snn_conv_mac_if #(
  parameter int unsigned K            = 3,
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned OUTPUT_WIDTH = 16
) ();
  logic                             spike_mode;
  logic signed [OUTPUT_WIDTH-1:0]   threshold;
  logic                             filt_valid;
  logic                             filt_ready;
  logic [K*K*FILTER_WIDTH-1:0]      filt_data;
  logic                             ifmap_valid;
  logic                             ifmap_ready;
  logic [K*K-1:0]                   ifmap_data;
  logic                             out_valid;
  logic                             out_ready;
  logic signed [OUTPUT_WIDTH-1:0]   out_psum;
  logic                             out_spike;

  modport slave (
    input  spike_mode, threshold, filt_valid, filt_data, ifmap_valid, ifmap_data, out_ready,
    output filt_ready, ifmap_ready, out_valid, out_psum, out_spike
  );

  modport master (
    output spike_mode, threshold, filt_valid, filt_data, ifmap_valid, ifmap_data, out_ready,
    input  filt_ready, ifmap_ready, out_valid, out_psum, out_spike
  );
endinterface

// File: rtl/snn_conv_mac.sv
// Spiking-convolution MAC: loads a KxK signed filter, accumulates binary-gated windows over
// NUM_CH channels per timestep, emits raw psum or integrate-and-fire result for NUM_T steps.
module snn_conv_mac #(
  parameter int unsigned K            = 3,
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned NUM_T        = 2
) (
  input logic          clk,
  input logic          rst,
  snn_conv_mac_if.slave bus
);

  localparam int unsigned Taps = K * K;
  // Wide enough for acc + full window sum and for V - threshold without overflow.
  localparam int unsigned SW   = OUTPUT_WIDTH + $clog2(Taps) + 2;
  localparam int unsigned CW   = $clog2(NUM_CH + 1);
  localparam int unsigned TW   = $clog2(NUM_T + 1);

  localparam logic signed [SW-1:0] MaxV = {{(SW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MinV = {{(SW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  state_e                          r_state, w_state_next;
  logic signed [FILTER_WIDTH-1:0]  r_w [Taps];
  logic                            r_spike_mode;
  logic signed [OUTPUT_WIDTH-1:0]  r_threshold;
  logic signed [OUTPUT_WIDTH-1:0]  r_acc;
  logic signed [OUTPUT_WIDTH-1:0]  r_v;
  logic signed [OUTPUT_WIDTH-1:0]  r_out_psum;
  logic                            r_out_spike;
  logic [CW-1:0]                   r_ch_cnt;
  logic [TW-1:0]                   r_t_cnt;

  logic                            w_filt_ready, w_ifmap_ready, w_out_valid;
  logic                            w_filt_fire, w_ifmap_fire, w_out_fire;
  logic                            w_last_ch, w_last_t;
  logic signed [SW-1:0]            w_win_sum;
  logic signed [OUTPUT_WIDTH-1:0]  w_acc_sum, w_vn, w_v_sub;
  logic                            w_fire;

  function automatic logic signed [OUTPUT_WIDTH-1:0] sat(input logic signed [SW-1:0] x);
    if (x > MaxV)      return MaxV[OUTPUT_WIDTH-1:0];
    else if (x < MinV) return MinV[OUTPUT_WIDTH-1:0];
    else               return x[OUTPUT_WIDTH-1:0];
  endfunction

  assign w_filt_fire  = bus.filt_valid && w_filt_ready;
  assign w_ifmap_fire = bus.ifmap_valid && w_ifmap_ready;
  assign w_out_fire   = bus.out_ready && w_out_valid;
  assign w_last_ch    = (r_ch_cnt == CW'(NUM_CH - 1));
  assign w_last_t     = (r_t_cnt == TW'(NUM_T - 1));

  always_comb begin
    w_win_sum = '0;
    for (int unsigned i = 0; i < Taps; i++) begin
      if (bus.ifmap_data[i]) w_win_sum = w_win_sum + SW'(r_w[i]);
    end
    w_acc_sum = sat(SW'(r_acc) + w_win_sum);
    w_vn      = sat(SW'(r_v) + SW'(w_acc_sum));
    w_fire    = (w_vn >= r_threshold);
    w_v_sub   = sat(SW'(w_vn) - SW'(r_threshold));
  end

  always_comb begin
    w_state_next  = r_state;
    w_filt_ready  = 1'b0;
    w_ifmap_ready = 1'b0;
    w_out_valid   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_filt_ready = 1'b1;
        if (bus.filt_valid) w_state_next = StAccum;
      end
      StAccum: begin
        w_ifmap_ready = 1'b1;
        if (bus.ifmap_valid && w_last_ch) w_state_next = StEmit;
      end
      StEmit: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = w_last_t ? StIdle : StAccum;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Taps; i++) r_w[i] <= '0;
      r_spike_mode <= 1'b0;
      r_threshold  <= '0;
      r_acc        <= '0;
      r_v          <= '0;
      r_out_psum   <= '0;
      r_out_spike  <= 1'b0;
      r_ch_cnt     <= '0;
      r_t_cnt      <= '0;
    end else begin
      if (w_filt_fire) begin
        for (int unsigned i = 0; i < Taps; i++) begin
          r_w[i] <= bus.filt_data[i*FILTER_WIDTH +: FILTER_WIDTH];
        end
        r_spike_mode <= bus.spike_mode;
        r_threshold  <= bus.threshold;
        r_acc        <= '0;
        r_v          <= '0;
        r_ch_cnt     <= '0;
        r_t_cnt      <= '0;
      end
      if (w_ifmap_fire) begin
        r_acc    <= w_acc_sum;
        r_ch_cnt <= r_ch_cnt + CW'(1);
        if (w_last_ch) begin
          if (r_spike_mode) begin
            r_out_spike <= w_fire;
            r_v         <= w_fire ? w_v_sub : w_vn;
            r_out_psum  <= w_fire ? w_v_sub : w_vn;
          end else begin
            r_out_spike <= 1'b0;
            r_out_psum  <= w_acc_sum;
          end
        end
      end
      if (w_out_fire) begin
        r_acc    <= '0;
        r_ch_cnt <= '0;
        if (w_last_t) begin
          r_t_cnt <= '0;
          r_v     <= '0;
        end else begin
          r_t_cnt <= r_t_cnt + TW'(1);
        end
      end
    end
  end

  assign bus.filt_ready  = w_filt_ready;
  assign bus.ifmap_ready = w_ifmap_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_psum    = r_out_psum;
  assign bus.out_spike   = r_out_spike;

endmodule
